cp0_exc_unit: RTL and testbench

- Parametrised successor to the combinational exception detector: a registered CP0 register file plus precise-exception commit logic for the MIPS-like pipeline, located at the memory/commit stage.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Prioritises exceptions and interrupts, and issues a single flush/redirect per event.
- Adds a Count/Compare timer interrupt, a configurable number of hardware interrupt lines with a synchroniser, branch-delay EPC correction and ERET handling.

---
 rtl/cp0_exc_unit_pkg.sv | 41 ++++
 rtl/cp0_exc_unit_timer.sv | 47 ++++
 rtl/cp0_exc_unit.sv | 155 +++++++++++++++
 tb/tb_cp0_exc_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_unit_pkg.sv
// rtl/cp0_exc_unit_pkg.sv - CP0 register numbers, ExcCodes and Status/Cause field positions
package cp0_exc_unit_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exc_code_e;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_BD     = 31;

  // Software may only touch IM, EXL and IE.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  function automatic logic [31:0] cause_word(input logic bd, input logic [7:0] ip,
                                             input logic [4:0] code);
    logic [31:0] w;
    w = '0;
    w[CA_BD] = bd;
    w[CA_IP_LO +: 8] = ip;
    w[CA_EXC_LO +: 5] = code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// rtl/cp0_exc_unit_timer.sv - Count/Compare timer with prescaler and sticky timer interrupt
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) count <= count + 32'd1;
      end
      // A Compare write acknowledges the timer interrupt even if Count matches.
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 register file with precise exception/interrupt commit and ERET redirect
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter int          HW_IRQ_NUM = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  commit_valid,
  input  logic [31:0]           pc,
  input  logic                  in_ds,
  input  logic                  adel_if,
  input  logic                  ri,
  input  logic                  ov,
  input  logic                  sys,
  input  logic                  bp,
  input  logic                  adel_d,
  input  logic                  ades_d,
  input  logic [31:0]           bad_addr,
  input  logic                  is_eret,
  input  logic [HW_IRQ_NUM-1:0] hw_int,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  output logic                  flush,
  output logic [31:0]           target_pc,
  output logic [4:0]            exc_code
);

  logic [HW_IRQ_NUM-1:0] irq_s1, irq_s2;
  logic [31:0] badvaddr, status, epc;
  logic        cause_bd;
  logic [4:0]  cause_code;
  logic [1:0]  ip_sw;
  logic [31:0] count, compare;
  logic        ti;

  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic        int_pend;
  logic        take_exc, eret_take, mtc0_ok;
  logic        bad_from_pc, bad_from_data;
  exc_code_e   code;

  always_comb begin
    hw_ip = '0;
    hw_ip[HW_IRQ_NUM-1:0] = irq_s2;
  end

  // IP7 is shared between the timer and the sixth hardware line.
  assign ip = {hw_ip[5] | ti, hw_ip[4:0], ip_sw};
  assign int_pend = status[ST_IE] & ~status[ST_EXL] & |(ip & status[ST_IM_LO +: 8]);

  always_comb begin
    take_exc      = 1'b0;
    code          = EXC_INT;
    bad_from_pc   = 1'b0;
    bad_from_data = 1'b0;
    if (commit_valid) begin
      take_exc = 1'b1;
      if (int_pend)     code = EXC_INT;
      else if (adel_if) begin
        code        = EXC_ADEL;
        bad_from_pc = 1'b1;
      end
      else if (ri)      code = EXC_RI;
      else if (ov)      code = EXC_OV;
      else if (sys)     code = EXC_SYS;
      else if (bp)      code = EXC_BP;
      else if (adel_d) begin
        code          = EXC_ADEL;
        bad_from_data = 1'b1;
      end
      else if (ades_d) begin
        code          = EXC_ADES;
        bad_from_data = 1'b1;
      end
      else take_exc = 1'b0;
    end
  end

  assign eret_take = commit_valid & is_eret & ~take_exc;
  assign mtc0_ok   = mtc0_we & ~take_exc;
  assign flush     = take_exc | eret_take;
  assign target_pc = take_exc ? EXC_VECTOR : (eret_take ? epc : 32'd0);
  assign exc_code  = take_exc ? code : EXC_INT;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (mtc0_ok && mtc0_addr == CP0_COUNT),
    .compare_we (mtc0_ok && mtc0_addr == CP0_COMPARE),
    .wdata      (mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_s1     <= '0;
      irq_s2     <= '0;
      badvaddr   <= '0;
      status     <= STATUS_RST;
      epc        <= '0;
      cause_bd   <= 1'b0;
      cause_code <= '0;
      ip_sw      <= '0;
    end else begin
      irq_s1 <= hw_int;
      irq_s2 <= irq_s1;
      if (take_exc) begin
        cause_code <= code;
        // A nested event keeps the EPC of the outermost handler.
        if (!status[ST_EXL]) begin
          epc      <= in_ds ? pc - 32'd4 : pc;
          cause_bd <= in_ds;
        end
        status[ST_EXL] <= 1'b1;
        if (bad_from_pc)        badvaddr <= pc;
        else if (bad_from_data) badvaddr <= bad_addr;
      end else begin
        if (mtc0_ok) begin
          case (mtc0_addr)
            CP0_STATUS: status <= (status & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
            CP0_CAUSE:  ip_sw  <= mtc0_wdata[CA_IP_LO +: 2];
            CP0_EPC:    epc    <= mtc0_wdata;
            default:    ;
          endcase
        end
        if (eret_take) status[ST_EXL] <= 1'b0;
      end
    end
  end

  always_comb begin
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_rdata = badvaddr;
      CP0_COUNT:    mfc0_rdata = count;
      CP0_COMPARE:  mfc0_rdata = compare;
      CP0_STATUS:   mfc0_rdata = status;
      CP0_CAUSE:    mfc0_rdata = cause_word(cause_bd, ip, cause_code);
      CP0_EPC:      mfc0_rdata = epc;
      default:      mfc0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - scoreboard bench for cp0_exc_unit against a behavioural CP0 model
module tb_cp0_exc_unit;

  localparam int          HW   = 6;
  localparam logic [31:0] VEC  = 32'hBFC00380;
  localparam int          CDIV = 2;
  localparam logic [31:0] SRST = 32'h00400000;
  localparam logic [31:0] WMSK = 32'h0000FF03;

  logic clk, resetn, commit_valid, in_ds, adel_if, ri, ov, sys, bp, adel_d, ades_d, is_eret, mtc0_we;
  logic [31:0] pc, bad_addr, mtc0_wdata, mfc0_rdata, target_pc;
  logic [HW-1:0] hw_int;
  logic [4:0] mtc0_addr, mfc0_addr, exc_code;
  logic flush;

  cp0_exc_unit #(
    .HW_IRQ_NUM (HW),
    .EXC_VECTOR (VEC),
    .COUNT_DIV  (CDIV),
    .STATUS_RST (SRST)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .commit_valid (commit_valid),
    .pc           (pc),
    .in_ds        (in_ds),
    .adel_if      (adel_if),
    .ri           (ri),
    .ov           (ov),
    .sys          (sys),
    .bp           (bp),
    .adel_d       (adel_d),
    .ades_d       (ades_d),
    .bad_addr     (bad_addr),
    .is_eret      (is_eret),
    .hw_int       (hw_int),
    .mtc0_we      (mtc0_we),
    .mtc0_addr    (mtc0_addr),
    .mtc0_wdata   (mtc0_wdata),
    .mfc0_addr    (mfc0_addr),
    .mfc0_rdata   (mfc0_rdata),
    .flush        (flush),
    .target_pc    (target_pc),
    .exc_code     (exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        flush;
    bit [31:0] target;
    bit [4:0]  code;
    bit [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  bit [31:0] m_badv, m_cmp, m_status, m_epc, m_load_val;
  bit        m_ti, m_bd;
  bit [4:0]  m_code;
  bit [1:0]  m_ipsw;
  int unsigned m_cyc, m_load_cyc;
  bit [5:0]  m_hist[$];
  bit [4:0]  codes [8] = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

  function automatic void chk(string name, bit [31:0] act, bit [31:0] exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    m_badv = 0; m_cmp = 0; m_status = SRST; m_epc = 0; m_load_val = 0;
    m_ti = 0; m_bd = 0; m_code = 0; m_ipsw = 0; m_cyc = 0; m_load_cyc = 0;
    m_hist.delete();
    m_hist.push_back(6'd0);
    m_hist.push_back(6'd0);
  endfunction

  // Count is the loaded value plus one per COUNT_DIV edges elapsed since the load.
  function automatic bit [31:0] m_count();
    return m_load_val + (m_cyc - m_load_cyc) / CDIV;
  endfunction

  task automatic clr();
    commit_valid = 0; pc = 0; in_ds = 0; adel_if = 0; ri = 0; ov = 0; sys = 0; bp = 0;
    adel_d = 0; ades_d = 0; bad_addr = 0; is_eret = 0; mtc0_we = 0; mtc0_addr = 0;
    mtc0_wdata = 0; mfc0_addr = 0;
  endtask

  // Inputs are already driven; predict this cycle's outputs, queue them, then advance the model.
  task automatic step();
    exp_t e;
    bit [7:0] ip;
    bit [31:0] cnt;
    bit conds [8];
    bit int_pend, take, ti_next;
    int idx;
    ip = {m_hist[0], m_ipsw};
    ip[7] = ip[7] | m_ti;
    int_pend = m_status[0] && !m_status[1] && ((ip & m_status[15:8]) != 0);
    conds = '{int_pend, adel_if, ri, ov, sys, bp, adel_d, ades_d};
    idx = -1;
    for (int i = 0; i < 8; i++) if (conds[i] && idx < 0) idx = i;
    take = commit_valid && idx >= 0;
    cnt = m_count();
    e.flush  = commit_valid && (take || is_eret);
    e.target = take ? VEC : (e.flush ? m_epc : 32'd0);
    e.code   = take ? codes[idx] : 5'd0;
    case (mfc0_addr)
      5'd8:    e.rdata = m_badv;
      5'd9:    e.rdata = cnt;
      5'd11:   e.rdata = m_cmp;
      5'd12:   e.rdata = m_status;
      5'd13:   e.rdata = {m_bd, 15'd0, ip, 1'b0, m_code, 2'b00};
      5'd14:   e.rdata = m_epc;
      default: e.rdata = 32'd0;
    endcase
    exp_q.push_back(e);
    if (resetn) begin
      ti_next = m_ti || (cnt == m_cmp);
      if (take) begin
        m_code = codes[idx];
        if (!m_status[1]) begin
          m_epc = in_ds ? pc - 32'd4 : pc;
          m_bd = in_ds;
        end
        m_status[1] = 1'b1;
        if (idx == 1) m_badv = pc;
        else if (idx >= 6) m_badv = bad_addr;
      end else begin
        if (mtc0_we) begin
          case (mtc0_addr)
            5'd9:  begin m_load_val = mtc0_wdata; m_load_cyc = m_cyc + 1; end
            5'd11: begin m_cmp = mtc0_wdata; ti_next = 0; end
            5'd12: m_status = (m_status & ~WMSK) | (mtc0_wdata & WMSK);
            5'd13: m_ipsw = mtc0_wdata[9:8];
            5'd14: m_epc = mtc0_wdata;
            default: ;
          endcase
        end
        if (commit_valid && is_eret) m_status[1] = 1'b0;
      end
      m_ti = ti_next;
      m_hist.push_back(6'(hw_int));
      void'(m_hist.pop_front());
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
    clr(); mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d; mfc0_addr = a; step();
  endtask

  task automatic rd(input bit [4:0] a);
    clr(); mfc0_addr = a; step();
  endtask

  task automatic reset_dut();
    resetn = 0;
    hw_int = '0;
    model_reset();
    clr();
    mfc0_addr = 5'd12; step();
    mfc0_addr = 5'd13; step();
    resetn = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("flush", 32'(flush), 32'(e.flush));
      if (e.flush) begin
        chk("target_pc", target_pc, e.target);
        chk("exc_code", 32'(exc_code), 32'(e.code));
      end
      chk("mfc0_rdata", mfc0_rdata, e.rdata);
    end
  end

  initial begin
    resetn = 0;
    hw_int = '0;
    clr();
    @(posedge clk);
    #1;
    reset_dut();
    for (int a = 8; a <= 15; a++) rd(5'(a));

    // syscall
    clr(); commit_valid = 1; pc = 32'hBFC00100; sys = 1; mfc0_addr = 5'd14; step();
    rd(14); rd(13); rd(12);

    // delay slot, then nested event under EXL
    mtc0(12, 32'h0);
    clr(); commit_valid = 1; pc = 32'h80001004; in_ds = 1; ov = 1; step();
    rd(14); rd(13);
    clr(); commit_valid = 1; pc = 32'h80005000; bp = 1; step();
    rd(14); rd(13);

    // priority and BadVAddr
    mtc0(12, 32'h0);
    clr(); commit_valid = 1; pc = 32'h80000100; ri = 1; adel_d = 1; bad_addr = 32'h12345678; step();
    rd(8); rd(13);
    mtc0(12, 32'h0);
    clr(); commit_valid = 1; pc = 32'h80000200; adel_d = 1; bad_addr = 32'h80000003; step();
    rd(8); rd(13);
    mtc0(12, 32'h0);
    clr(); commit_valid = 1; pc = 32'h80000301; adel_if = 1; ri = 1; step();
    rd(8); rd(13);

    // timer interrupt
    mtc0(12, 32'h0);
    mtc0(9, 32'h0);
    mtc0(11, 32'd5);
    mtc0(12, 32'h0000_8001);
    for (int i = 0; i < 14; i++) rd(13);
    clr(); commit_valid = 1; pc = 32'h80000400; step();
    rd(13); rd(12);
    mtc0(12, 32'h0);
    mtc0(11, 32'd5);
    rd(13);

    // ERET with concurrent EPC write
    mtc0(14, 32'h80002000);
    mtc0(12, 32'h0000_0002);
    clr(); commit_valid = 1; is_eret = 1; mtc0_we = 1; mtc0_addr = 5'd14;
    mtc0_wdata = 32'hDEAD0000; mfc0_addr = 5'd14; step();
    rd(12); rd(14);

    // hardware interrupt through the synchroniser
    mtc0(12, 32'h0000_0401);
    clr(); hw_int = 6'b000001; mfc0_addr = 5'd13; step();
    for (int i = 0; i < 4; i++) rd(13);
    clr(); commit_valid = 1; pc = 32'h80000500; mfc0_addr = 5'd13; step();
    hw_int = '0;
    rd(13); rd(13); rd(13);

    // reset in the middle of activity
    mtc0(14, 32'h11112222);
    reset_dut();
    rd(14); rd(12); rd(13); rd(9);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if (n == 400) reset_dut();
      clr();
      commit_valid = ($urandom_range(0, 9) < 7);
      pc = $urandom & 32'hFFFF_FFFC;
      in_ds = ($urandom_range(0, 4) == 0);
      adel_if = ($urandom_range(0, 24) == 0);
      ri = ($urandom_range(0, 24) == 0);
      ov = ($urandom_range(0, 24) == 0);
      sys = ($urandom_range(0, 24) == 0);
      bp = ($urandom_range(0, 24) == 0);
      adel_d = ($urandom_range(0, 24) == 0);
      ades_d = ($urandom_range(0, 24) == 0);
      bad_addr = $urandom;
      is_eret = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = HW'($urandom);
      mtc0_we = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: mtc0_addr = 5'd9;
        1: mtc0_addr = 5'd11;
        2: mtc0_addr = 5'd12;
        3: mtc0_addr = 5'd13;
        4: mtc0_addr = 5'd14;
        default: mtc0_addr = 5'($urandom_range(0, 31));
      endcase
      mtc0_wdata = $urandom;
      if (mtc0_addr == 5'd11) mtc0_wdata = m_count() + $urandom_range(1, 40);
      mfc0_addr = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(8, 14));
      step();
    end

    clr();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
